// File: rtl/shift_restore_if.sv
// Request/response bundle for shift_restore: per-lane shifted result, overflow and descriptor in,
// restored operand and descriptor error out, each side with a valid/ready handshake.
interface shift_restore_if #(
   parameter int WIDTH = 4,
   parameter int SETS  = 2
);
   logic                   in_valid;
   logic                   in_ready;
   logic [SETS*WIDTH-1:0]  shifted_packed;
   logic [SETS*WIDTH-1:0]  overflow_packed;
   logic [SETS*WIDTH-1:0]  shift_packed;
   logic                   out_valid;
   logic                   out_ready;
   logic [SETS*WIDTH-1:0]  restored_packed;
   logic [SETS-1:0]        err_packed;

   modport master (
      output in_valid, shifted_packed, overflow_packed, shift_packed, out_ready,
      input  in_ready, out_valid, restored_packed, err_packed
   );

   modport slave (
      input  in_valid, shifted_packed, overflow_packed, shift_packed, out_ready,
      output in_ready, out_valid, restored_packed, err_packed
   );
endinterface

// File: rtl/shift_restore.sv
// Undo of the packed lane shifter: rebuilds each lane's pre-shift operand from its shifted
// result, overflow word and descriptor, moving one bit position per clock per lane.
module shift_restore #(
   parameter int WIDTH = 4,
   parameter int SETS  = 2
) (
   input logic            clk,
   input logic            rst,
   shift_restore_if.slave bus
);
   if (WIDTH < 2) begin : g_width_check
      $error("shift_restore: WIDTH must be >= 2");
   end

   typedef enum logic [1:0] {IDLE, SHIFT, MERGE, DONE} state_t;

   localparam logic [WIDTH-1:0] ONES     = '1;
   localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
   localparam logic [WIDTH-1:0] WLIM     = WIDTH'(WIDTH);
   localparam logic [WIDTH-1:0] AMT_MASK = ~(ONES << (WIDTH-2));

   state_t state_q, state_d;

   logic [2*WIDTH-1:0]    work_q [SETS];
   logic [WIDTH-1:0]      cnt_q  [SETS];
   logic [WIDTH-1:0]      amt_q  [SETS];
   logic [WIDTH-1:0]      ovf_q  [SETS];
   logic [SETS-1:0]       dir_q, err_q;
   logic [SETS*WIDTH-1:0] restored_q;
   logic [SETS-1:0]       err_out_q;

   logic [WIDTH-1:0]      amt_in [SETS];
   logic [SETS-1:0]       dir_in, err_in;
   logic                  busy;
   logic [SETS*WIDTH-1:0] merged;
   logic                  in_ready_c, out_valid_c;

   // Descriptor decode: amount sits above the direction bit, fill bit is masked off.
   always_comb begin
      dir_in = '0;
      err_in = '0;
      busy   = 1'b0;
      for (int unsigned i = 0; i < SETS; i++) begin
         amt_in[i] = (bus.shift_packed[i*WIDTH +: WIDTH] >> 1) & AMT_MASK;
         dir_in[i] = bus.shift_packed[i*WIDTH];
         err_in[i] = (amt_in[i] >= WLIM);
         if (cnt_q[i] != '0) busy = 1'b1;
      end
   end

   // Right lanes recover their low bits from the overflow word; vacated fill bits were shifted out.
   always_comb begin
      merged = '0;
      for (int unsigned i = 0; i < SETS; i++) begin
         if (err_q[i])
            merged[i*WIDTH +: WIDTH] = '0;
         else if (dir_q[i])
            merged[i*WIDTH +: WIDTH] = work_q[i][WIDTH-1:0] | (ovf_q[i] & ~(ONES << amt_q[i]));
         else
            merged[i*WIDTH +: WIDTH] = work_q[i][WIDTH-1:0];
      end
   end

   always_comb begin
      state_d     = state_q;
      in_ready_c  = 1'b0;
      out_valid_c = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready_c = 1'b1;
            if (bus.in_valid) state_d = SHIFT;
         end
         SHIFT: if (!busy) state_d = MERGE;
         MERGE: state_d = DONE;
         DONE: begin
            out_valid_c = 1'b1;
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         dir_q      <= '0;
         err_q      <= '0;
         restored_q <= '0;
         err_out_q  <= '0;
         for (int unsigned i = 0; i < SETS; i++) begin
            work_q[i] <= '0;
            cnt_q[i]  <= '0;
            amt_q[i]  <= '0;
            ovf_q[i]  <= '0;
         end
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: if (bus.in_valid) begin
               dir_q <= dir_in;
               err_q <= err_in;
               for (int unsigned i = 0; i < SETS; i++) begin
                  amt_q[i] <= amt_in[i];
                  ovf_q[i] <= bus.overflow_packed[i*WIDTH +: WIDTH];
                  cnt_q[i] <= err_in[i] ? '0 : amt_in[i];
                  if (dir_in[i])
                     work_q[i] <= {{WIDTH{1'b0}}, bus.shifted_packed[i*WIDTH +: WIDTH]};
                  else
                     work_q[i] <= {bus.overflow_packed[i*WIDTH +: WIDTH],
                                   bus.shifted_packed[i*WIDTH +: WIDTH]};
               end
            end
            SHIFT: begin
               for (int unsigned i = 0; i < SETS; i++) begin
                  if (cnt_q[i] != '0) begin
                     cnt_q[i] <= cnt_q[i] - ONE;
                     if (dir_q[i])
                        work_q[i] <= {{WIDTH{1'b0}}, work_q[i][WIDTH-2:0], 1'b0};
                     else
                        work_q[i] <= work_q[i] >> 1;
                  end
               end
            end
            MERGE: begin
               restored_q <= merged;
               err_out_q  <= err_q;
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready        = in_ready_c;
   assign bus.out_valid       = out_valid_c;
   assign bus.restored_packed = restored_q;
   assign bus.err_packed      = err_out_q;
endmodule
